// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU skid FIFOs feed a round-robin scheduler that
// grants up to CDB_WIDTH results per cycle onto registered broadcast slots.
module cdb_arbiter #(
    parameter int N_REQ      = 4,
    parameter int CDB_WIDTH  = 2,
    parameter int DATA_W     = 32,
    parameter int PRF_IDX    = 6,
    parameter int ROB_IDX    = 5,
    parameter int ARCH_IDX   = 5,
    parameter int FIFO_DEPTH = 2,
    localparam int SRC_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*ROB_IDX-1:0]      req_rob_id,
    input  logic [N_REQ*PRF_IDX-1:0]      req_rd_phy,
    input  logic [N_REQ*ARCH_IDX-1:0]     req_rd_arch,
    input  logic [N_REQ*DATA_W-1:0]       req_rd_value,
    output logic [CDB_WIDTH-1:0]          cdb_valid,
    output logic [CDB_WIDTH*ROB_IDX-1:0]  cdb_rob_id,
    output logic [CDB_WIDTH*PRF_IDX-1:0]  cdb_rd_phy,
    output logic [CDB_WIDTH*ARCH_IDX-1:0] cdb_rd_arch,
    output logic [CDB_WIDTH*DATA_W-1:0]   cdb_rd_value,
    output logic [CDB_WIDTH*SRC_W-1:0]    cdb_src
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SLOT_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

    // Per-requester FIFO state
    logic [CNT_W-1:0]    r_count  [N_REQ];
    logic [PTR_W-1:0]    r_wr_ptr [N_REQ];
    logic [PTR_W-1:0]    r_rd_ptr [N_REQ];
    logic [ROB_IDX-1:0]  r_mem_rob   [N_REQ][FIFO_DEPTH];
    logic [PRF_IDX-1:0]  r_mem_phy   [N_REQ][FIFO_DEPTH];
    logic [ARCH_IDX-1:0] r_mem_arch  [N_REQ][FIFO_DEPTH];
    logic [DATA_W-1:0]   r_mem_value [N_REQ][FIFO_DEPTH];

    logic [SRC_W-1:0]    r_rr_ptr;

    // Registered broadcast slots
    logic [CDB_WIDTH-1:0] r_cdb_valid;
    logic [ROB_IDX-1:0]   r_cdb_rob   [CDB_WIDTH];
    logic [PRF_IDX-1:0]   r_cdb_phy   [CDB_WIDTH];
    logic [ARCH_IDX-1:0]  r_cdb_arch  [CDB_WIDTH];
    logic [DATA_W-1:0]    r_cdb_value [CDB_WIDTH];
    logic [SRC_W-1:0]     r_cdb_src   [CDB_WIDTH];

    // Combinational grant results
    logic [N_REQ-1:0]     w_enq;
    logic [N_REQ-1:0]     w_deq;
    logic [CDB_WIDTH-1:0] w_slot_vld;
    logic [SRC_W-1:0]     w_slot_src   [CDB_WIDTH];
    logic [ROB_IDX-1:0]   w_slot_rob   [CDB_WIDTH];
    logic [PRF_IDX-1:0]   w_slot_phy   [CDB_WIDTH];
    logic [ARCH_IDX-1:0]  w_slot_arch  [CDB_WIDTH];
    logic [DATA_W-1:0]    w_slot_value [CDB_WIDTH];
    logic [SRC_W-1:0]     w_next_rr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Ready comes only from the registered count, so it is stable all cycle.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (int'(r_count[i]) < FIFO_DEPTH);
        end
    end

    assign w_enq = req_valid & req_ready & {N_REQ{~flush}};

    // NOTE: every output of a combinational block gets a default first so no
    // path through the loop can leave a value unassigned and infer a latch.
    always_comb begin : arb
        int               n_grant;
        logic [SRC_W-1:0] idx;
        logic [SLOT_W-1:0] slot;
        w_deq      = '0;
        w_slot_vld = '0;
        w_next_rr  = r_rr_ptr;
        n_grant    = 0;
        idx        = '0;
        slot       = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            w_slot_src[k]   = '0;
            w_slot_rob[k]   = '0;
            w_slot_phy[k]   = '0;
            w_slot_arch[k]  = '0;
            w_slot_value[k] = '0;
        end
        for (int off = 0; off < N_REQ; off++) begin
            idx = SRC_W'((int'(r_rr_ptr) + off) % N_REQ);
            if (r_count[idx] != '0 && n_grant < CDB_WIDTH) begin
                slot               = SLOT_W'(n_grant);
                w_slot_vld[slot]   = 1'b1;
                w_slot_src[slot]   = idx;
                w_slot_rob[slot]   = r_mem_rob[idx][r_rd_ptr[idx]];
                w_slot_phy[slot]   = r_mem_phy[idx][r_rd_ptr[idx]];
                w_slot_arch[slot]  = r_mem_arch[idx][r_rd_ptr[idx]];
                w_slot_value[slot] = r_mem_value[idx][r_rd_ptr[idx]];
                w_deq[idx]         = 1'b1;
                w_next_rr          = SRC_W'((int'(idx) + 1) % N_REQ);
                n_grant            = n_grant + 1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_count[i]  <= '0;
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_count[i]  <= '0;
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_enq[i]) r_wr_ptr[i] <= ptr_inc(r_wr_ptr[i]);
                if (w_deq[i]) r_rd_ptr[i] <= ptr_inc(r_rd_ptr[i]);
                case ({w_enq[i], w_deq[i]})
                    2'b10:   r_count[i] <= r_count[i] + 1'b1;
                    2'b01:   r_count[i] <= r_count[i] - 1'b1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an entry is only read
    // after the count says it was written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (w_enq[i]) begin
                r_mem_rob[i][r_wr_ptr[i]]   <= req_rob_id[i*ROB_IDX +: ROB_IDX];
                r_mem_phy[i][r_wr_ptr[i]]   <= req_rd_phy[i*PRF_IDX +: PRF_IDX];
                r_mem_arch[i][r_wr_ptr[i]]  <= req_rd_arch[i*ARCH_IDX +: ARCH_IDX];
                r_mem_value[i][r_wr_ptr[i]] <= req_rd_value[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grants made in a flush cycle are discarded with the FIFOs, so the
    // round-robin pointer only advances on grants that actually broadcast.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (!flush) begin
            r_rr_ptr <= w_next_rr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb_valid <= '0;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                r_cdb_rob[k]   <= '0;
                r_cdb_phy[k]   <= '0;
                r_cdb_arch[k]  <= '0;
                r_cdb_value[k] <= '0;
                r_cdb_src[k]   <= '0;
            end
        end else if (flush) begin
            r_cdb_valid <= '0;
        end else begin
            r_cdb_valid <= w_slot_vld;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                if (w_slot_vld[k]) begin
                    r_cdb_rob[k]   <= w_slot_rob[k];
                    r_cdb_phy[k]   <= w_slot_phy[k];
                    r_cdb_arch[k]  <= w_slot_arch[k];
                    r_cdb_value[k] <= w_slot_value[k];
                    r_cdb_src[k]   <= w_slot_src[k];
                end
            end
        end
    end

    assign cdb_valid = r_cdb_valid;

    for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_slot
        assign cdb_rob_id[k*ROB_IDX +: ROB_IDX]    = r_cdb_rob[k];
        assign cdb_rd_phy[k*PRF_IDX +: PRF_IDX]    = r_cdb_phy[k];
        assign cdb_rd_arch[k*ARCH_IDX +: ARCH_IDX] = r_cdb_arch[k];
        assign cdb_rd_value[k*DATA_W +: DATA_W]    = r_cdb_value[k];
        assign cdb_src[k*SRC_W +: SRC_W]           = r_cdb_src[k];
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a queue-based model of the FIFOs and the
// round-robin rule is compared every cycle, plus hand-computed literal checks.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int DW = 32;
    localparam int PW = 6;
    localparam int RW = 5;
    localparam int AW = 5;
    localparam int SW = 2;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*RW-1:0] req_rob_id = '0;
    logic [N*PW-1:0] req_rd_phy = '0;
    logic [N*AW-1:0] req_rd_arch = '0;
    logic [N*DW-1:0] req_rd_value = '0;
    logic [W-1:0]    cdb_valid;
    logic [W*RW-1:0] cdb_rob_id;
    logic [W*PW-1:0] cdb_rd_phy;
    logic [W*AW-1:0] cdb_rd_arch;
    logic [W*DW-1:0] cdb_rd_value;
    logic [W*SW-1:0] cdb_src;

    cdb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rob_id   (req_rob_id),
        .req_rd_phy   (req_rd_phy),
        .req_rd_arch  (req_rd_arch),
        .req_rd_value (req_rd_value),
        .cdb_valid    (cdb_valid),
        .cdb_rob_id   (cdb_rob_id),
        .cdb_rd_phy   (cdb_rd_phy),
        .cdb_rd_arch  (cdb_rd_arch),
        .cdb_rd_value (cdb_rd_value),
        .cdb_src      (cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [PW-1:0] phy;
        logic [AW-1:0] arch;
        logic [DW-1:0] val;
    } res_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per requester, round-robin pointer as an int.
    res_t         mq[N][$];
    int           m_rr;
    logic [W-1:0] m_valid;
    res_t         m_slot [W];
    logic [SW-1:0] m_src [W];

    always @(posedge clk or negedge rst) begin
        logic [N-1:0] rdy;
        int           ng;
        int           last;
        int           idx;
        if (!rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr    = 0;
            m_valid = '0;
            for (int k = 0; k < W; k++) begin
                m_slot[k] = '0;
                m_src[k]  = '0;
            end
        end else if (flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = '0;
        end else begin
            for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < DEPTH);
            ng      = 0;
            last    = 0;
            m_valid = '0;
            for (int off = 0; off < N; off++) begin
                idx = (m_rr + off) % N;
                if (mq[idx].size() > 0 && ng < W) begin
                    m_slot[ng]  = mq[idx].pop_front();
                    m_src[ng]   = SW'(idx);
                    m_valid[ng] = 1'b1;
                    last        = idx;
                    ng++;
                end
            end
            if (ng > 0) m_rr = (last + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && rdy[i]) begin
                    mq[i].push_back('{req_rob_id[i*RW +: RW], req_rd_phy[i*PW +: PW],
                                      req_rd_arch[i*AW +: AW], req_rd_value[i*DW +: DW]});
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] er;
        if (rst) begin
            for (int i = 0; i < N; i++) er[i] = (mq[i].size() < DEPTH);
            check("mdl_req_ready", req_ready, er);
            check("mdl_cdb_valid", cdb_valid, m_valid);
            for (int k = 0; k < W; k++) begin
                check($sformatf("mdl_src%0d", k),   cdb_src[k*SW +: SW],      m_src[k]);
                check($sformatf("mdl_rob%0d", k),   cdb_rob_id[k*RW +: RW],   m_slot[k].rob);
                check($sformatf("mdl_phy%0d", k),   cdb_rd_phy[k*PW +: PW],   m_slot[k].phy);
                check($sformatf("mdl_arch%0d", k),  cdb_rd_arch[k*AW +: AW],  m_slot[k].arch);
                check($sformatf("mdl_value%0d", k), cdb_rd_value[k*DW +: DW], m_slot[k].val);
            end
        end
    end

    // Stimulus: requester i offers its seq[i]-th result while en[i] is set.
    int           seq [N];
    logic [N-1:0] en = '0;

    function automatic res_t mk(input int i, input int s);
        res_t r;
        r.rob  = RW'((i * 8 + s) % 32);
        r.phy  = PW'((i * 16 + s * 5) % 64);
        r.arch = AW'((s * 3 + i) % 32);
        r.val  = {4'(i), 28'(s * 977 + 12345)};
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            res_t r;
            r = mk(i, seq[i]);
            req_valid[i]                = en[i];
            req_rob_id[i*RW +: RW]      = r.rob;
            req_rd_phy[i*PW +: PW]      = r.phy;
            req_rd_arch[i*AW +: AW]     = r.arch;
            req_rd_value[i*DW +: DW]    = r.val;
        end
    endtask

    // One clock: note what will be accepted, cross the edge, present the next items.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready & {N{~flush}};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
        drive();
    endtask

    logic [N-1:0] pats [12] = '{4'b1010, 4'b0110, 4'b1111, 4'b0001, 4'b1000, 4'b1100,
                                4'b0011, 4'b0101, 4'b1111, 4'b0100, 4'b1001, 4'b0000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        #1 rst = 1'b0;
        #3;
        check("rst_async_valid", cdb_valid, 2'b00);
        check("rst_async_ready", req_ready, 4'b1111);
        check("rst_async_src",   cdb_src,   4'b0000);
        check("rst_async_rob",   cdb_rob_id, 10'd0);
        check("rst_async_value", cdb_rd_value, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_held_valid", cdb_valid, 2'b00);
        check("rst_held_ready", req_ready, 4'b1111);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single result through requester 0.
        req_rob_id[4:0]    = 5'd3;
        req_rd_phy[5:0]    = 6'd17;
        req_rd_arch[4:0]   = 5'd5;
        req_rd_value[31:0] = 32'hDEADBEEF;
        req_valid          = 4'b0001;
        check("pt_ready0", req_ready, 4'b1111);
        @(posedge clk);
        #1;
        req_valid = '0;
        check("pt_ready1", req_ready, 4'b1111);
        check("pt_valid1", cdb_valid, 2'b00);
        @(posedge clk);
        #1;
        check("pt_valid2", cdb_valid, 2'b01);
        check("pt_src0",   cdb_src[1:0], 2'd0);
        check("pt_rob",    cdb_rob_id[4:0], 5'd3);
        check("pt_phy",    cdb_rd_phy[5:0], 6'd17);
        check("pt_arch",   cdb_rd_arch[4:0], 5'd5);
        check("pt_value",  cdb_rd_value[31:0], 32'hDEADBEEF);
        check("pt_ready2", req_ready, 4'b1111);
        @(posedge clk);
        #1;
        check("pt_valid3", cdb_valid, 2'b00);

        // Requester 1 alone: enqueue while its single entry is granted.
        seq[1] = 4;
        en     = 4'b0010;
        drive();
        step();
        check("ss_valid0", cdb_valid, 2'b00);
        step();
        check("ss_valid1", cdb_valid, 2'b01);
        check("ss_src1",   cdb_src[1:0], 2'd1);
        check("ss_rob1",   cdb_rob_id[4:0], 5'd12);
        check("ss_ready1", req_ready, 4'b1111);
        en = '0;
        step();
        check("ss_valid2", cdb_valid, 2'b01);
        check("ss_rob2",   cdb_rob_id[4:0], 5'd13);
        check("ss_ready2", req_ready, 4'b1111);
        step();
        check("ss_rob3",   cdb_rob_id[4:0], 5'd14);
        step();
        check("ss_valid4", cdb_valid, 2'b00);

        // Full traffic, then asynchronous reset between edges.
        for (int i = 0; i < N; i++) seq[i] = 0;
        en = 4'b1111;
        drive();
        repeat (8) step();
        #2 rst = 1'b0;
        #1;
        check("ar_valid", cdb_valid, 2'b00);
        check("ar_ready", req_ready, 4'b1111);
        check("ar_src",   cdb_src, 4'b0000);
        en = '0;
        drive();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin from a fresh pointer with all requesters streaming.
        for (int i = 0; i < N; i++) seq[i] = 0;
        en = 4'b1111;
        drive();
        step();
        check("rr_valid0", cdb_valid, 2'b00);
        step();
        check("rr_a_valid", cdb_valid, 2'b11);
        check("rr_a_src",   cdb_src, {2'd1, 2'd0});
        check("rr_a_rob",   cdb_rob_id, {5'd8, 5'd0});
        check("bp_ready_a", req_ready, 4'b0011);
        step();
        check("rr_b_src",   cdb_src, {2'd3, 2'd2});
        check("rr_b_rob",   cdb_rob_id, {5'd24, 5'd16});
        check("bp_ready_b", req_ready, 4'b1100);
        step();
        check("rr_c_src",   cdb_src, {2'd1, 2'd0});
        check("rr_c_rob",   cdb_rob_id, {5'd9, 5'd1});
        check("bp_ready_c", req_ready, 4'b0011);
        repeat (6) step();

        // Flush with inputs still offered in the flush cycle.
        flush = 1'b1;
        en    = '0;
        step();
        flush = 1'b0;
        check("fl_valid", cdb_valid, 2'b00);
        check("fl_ready", req_ready, 4'b1111);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("fl_idle%0d", c), cdb_valid, 2'b00);
        end

        // Irregular offer patterns, each held for two cycles.
        for (int p = 0; p < 12; p++) begin
            en = pats[p];
            step();
            step();
        end
        en = '0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
